agc_ctrl: RTL and testbench

Sequencer for a bank of agc_dsp lanes sharing one scale/offset setting. Stages software scale/offset writes into the DSP first-stage registers (ce_scale/ce_offset). Issues the global apply only between measurement windows. Runs timed measurement windows that accumulate per-lane abs² and gt/lt saturation counts, which the AGC loop uses to compute the next scale/offset.

---
 rtl/agc_pkg.sv | 32 +++
 rtl/agc_ctrl_if.sv | 46 ++++
 rtl/agc_sq_tree.sv | 37 +++
 rtl/agc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_agc_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agc_pkg.sv
// Shared state encoding, default widths and arithmetic helpers for the AGC controller.
package agc_pkg;

    localparam int unsigned DEF_NLANE    = 8;
    localparam int unsigned DEF_ABS_BITS = 4;
    localparam int unsigned DEF_WIN_BITS = 24;
    localparam int unsigned DEF_ACC_BITS = 40;
    localparam int unsigned DEF_SETTLE   = 6;

    localparam int unsigned SQ_BITS = 2 * DEF_ABS_BITS;
    localparam int unsigned CNT_W   = DEF_WIN_BITS + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_APPLY,
        S_SETTLE
    } agc_state_t;

    // Unsigned add clamped to the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        lim = (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/agc_ctrl_if.sv
// Host-side controls, DSP setting outputs and measurement results of the AGC controller.
interface agc_ctrl_if
    import agc_pkg::*;
#(
    parameter int unsigned NLANE    = DEF_NLANE,
    parameter int unsigned ABS_BITS = DEF_ABS_BITS,
    parameter int unsigned WIN_BITS = DEF_WIN_BITS,
    parameter int unsigned ACC_BITS = DEF_ACC_BITS
);
    logic [16:0]                scale_dat_i;
    logic                       scale_wr_i;
    logic [11:0]                offset_dat_i;
    logic                       offset_wr_i;
    logic                       apply_req_i;
    logic                       start_i;
    logic [WIN_BITS-1:0]        window_len_i;
    logic [NLANE*ABS_BITS-1:0]  abs_i;
    logic [NLANE-1:0]           gt_i;
    logic [NLANE-1:0]           lt_i;

    logic [16:0]                scale_o;
    logic [11:0]                offset_o;
    logic                       ce_scale_o;
    logic                       ce_offset_o;
    logic                       apply_o;
    logic                       busy_o;
    logic                       done_o;
    logic [ACC_BITS-1:0]        sq_sum_o;
    logic [WIN_BITS+3:0]        gt_cnt_o;
    logic [WIN_BITS+3:0]        lt_cnt_o;

    modport master (
        output scale_dat_i, scale_wr_i, offset_dat_i, offset_wr_i,
               apply_req_i, start_i, window_len_i, abs_i, gt_i, lt_i,
        input  scale_o, offset_o, ce_scale_o, ce_offset_o, apply_o,
               busy_o, done_o, sq_sum_o, gt_cnt_o, lt_cnt_o
    );

    modport slave (
        input  scale_dat_i, scale_wr_i, offset_dat_i, offset_wr_i,
               apply_req_i, start_i, window_len_i, abs_i, gt_i, lt_i,
        output scale_o, offset_o, ce_scale_o, ce_offset_o, apply_o,
               busy_o, done_o, sq_sum_o, gt_cnt_o, lt_cnt_o
    );

endinterface

// File: rtl/agc_sq_tree.sv
// Sum of squared lane magnitudes across all lanes, registered once (1-clock latency).
module agc_sq_tree
    import agc_pkg::*;
#(
    parameter int unsigned NLANE    = DEF_NLANE,
    parameter int unsigned ABS_BITS = DEF_ABS_BITS,
    localparam int unsigned SQ_W    = 2 * ABS_BITS,
    localparam int unsigned OUT_W   = SQ_W + $clog2(NLANE)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NLANE*ABS_BITS-1:0] abs_i,
    output logic [OUT_W-1:0]          sum_o
);

    logic [OUT_W-1:0] sum_c;
    logic [SQ_W-1:0]  lane;

    // Operands are widened before squaring so the product never truncates.
    always_comb begin
        sum_c = '0;
        lane  = '0;
        for (int k = 0; k < int'(NLANE); k++) begin
            lane  = SQ_W'(abs_i[k*ABS_BITS +: ABS_BITS]);
            sum_c = sum_c + OUT_W'(lane * lane);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_o <= '0;
        end else begin
            sum_o <= sum_c;
        end
    end

endmodule

// File: rtl/agc_ctrl.sv
// AGC sequencer: stages scale/offset writes, gates the global apply between windows,
// and runs timed abs^2 / saturation-count measurement windows over all lanes.
module agc_ctrl
    import agc_pkg::*;
#(
    parameter int unsigned NLANE    = DEF_NLANE,
    parameter int unsigned ABS_BITS = DEF_ABS_BITS,
    parameter int unsigned WIN_BITS = DEF_WIN_BITS,
    parameter int unsigned ACC_BITS = DEF_ACC_BITS,
    parameter int unsigned SETTLE   = DEF_SETTLE
) (
    input  logic      clk_i,
    input  logic      rst_i,
    agc_ctrl_if.slave bus
);

    localparam int unsigned SQ_W     = 2 * ABS_BITS;
    localparam int unsigned TREE_W   = SQ_W + $clog2(NLANE);
    localparam int unsigned CNT_BITS = WIN_BITS + 4;
    localparam int unsigned PC_W     = $clog2(NLANE + 1);
    localparam int unsigned SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    agc_state_t          state;
    logic                apply_pend;
    logic                start_pend;
    logic                samp_v;
    logic [WIN_BITS-1:0] win_cnt;
    logic [WIN_BITS-1:0] win_len;
    logic [SET_W-1:0]    set_cnt;
    logic [ACC_BITS-1:0] acc;
    logic [CNT_BITS-1:0] gt_acc;
    logic [CNT_BITS-1:0] lt_acc;
    logic [TREE_W-1:0]   tree_sum;
    logic [PC_W-1:0]     gt_pc;
    logic [PC_W-1:0]     lt_pc;

    logic [ACC_BITS-1:0] acc_next_c;
    logic [CNT_BITS-1:0] gt_next_c;
    logic [CNT_BITS-1:0] lt_next_c;

    agc_sq_tree #(
        .NLANE    (NLANE),
        .ABS_BITS (ABS_BITS)
    ) u_sq_tree (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .abs_i (bus.abs_i),
        .sum_o (tree_sum)
    );

    // Popcounts ride alongside the square tree so one valid flag covers both.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gt_pc  <= '0;
            lt_pc  <= '0;
            samp_v <= 1'b0;
        end else begin
            gt_pc  <= PC_W'($countones(bus.gt_i));
            lt_pc  <= PC_W'($countones(bus.lt_i));
            samp_v <= (state == S_RUN);
        end
    end

    always_comb begin
        acc_next_c = acc;
        gt_next_c  = gt_acc;
        lt_next_c  = lt_acc;
        if (samp_v) begin
            acc_next_c = ACC_BITS'(sat_add(64'(acc), 64'(tree_sum), ACC_BITS));
            gt_next_c  = gt_acc + CNT_BITS'(gt_pc);
            lt_next_c  = lt_acc + CNT_BITS'(lt_pc);
        end
    end

    // First-stage DSP register loads, independent of the sequencer state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.scale_o     <= '0;
            bus.offset_o    <= '0;
            bus.ce_scale_o  <= 1'b0;
            bus.ce_offset_o <= 1'b0;
        end else begin
            bus.ce_scale_o  <= bus.scale_wr_i;
            bus.ce_offset_o <= bus.offset_wr_i;
            if (bus.scale_wr_i) begin
                bus.scale_o <= bus.scale_dat_i;
            end
            if (bus.offset_wr_i) begin
                bus.offset_o <= bus.offset_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            apply_pend   <= 1'b0;
            start_pend   <= 1'b0;
            win_cnt      <= '0;
            win_len      <= '0;
            set_cnt      <= '0;
            acc          <= '0;
            gt_acc       <= '0;
            lt_acc       <= '0;
            bus.apply_o  <= 1'b0;
            bus.busy_o   <= 1'b0;
            bus.done_o   <= 1'b0;
            bus.sq_sum_o <= '0;
            bus.gt_cnt_o <= '0;
            bus.lt_cnt_o <= '0;
        end else begin
            bus.apply_o <= 1'b0;
            bus.done_o  <= 1'b0;
            acc         <= acc_next_c;
            gt_acc      <= gt_next_c;
            lt_acc      <= lt_next_c;
            if (bus.apply_req_i) begin
                apply_pend <= 1'b1;
            end
            if (bus.start_i && (state != S_RUN)) begin
                start_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (apply_pend) begin
                        state       <= S_APPLY;
                        bus.apply_o <= 1'b1;
                        bus.busy_o  <= 1'b1;
                    end else if (start_pend) begin
                        state      <= S_RUN;
                        bus.busy_o <= 1'b1;
                        start_pend <= bus.start_i;
                        win_cnt    <= '0;
                        win_len    <= (bus.window_len_i == '0) ? WIN_BITS'(1) : bus.window_len_i;
                        acc        <= '0;
                        gt_acc     <= '0;
                        lt_acc     <= '0;
                    end
                end
                S_RUN: begin
                    if (win_cnt == (win_len - WIN_BITS'(1))) begin
                        state <= S_DONE;
                    end else begin
                        win_cnt <= win_cnt + WIN_BITS'(1);
                    end
                end
                // Tree output of the last sample is folded in here, hence the _next_c totals.
                S_DONE: begin
                    state        <= S_IDLE;
                    bus.busy_o   <= 1'b0;
                    bus.done_o   <= 1'b1;
                    bus.sq_sum_o <= acc_next_c;
                    bus.gt_cnt_o <= gt_next_c;
                    bus.lt_cnt_o <= lt_next_c;
                end
                S_APPLY: begin
                    state      <= S_SETTLE;
                    set_cnt    <= '0;
                    apply_pend <= bus.apply_req_i;
                end
                S_SETTLE: begin
                    if (set_cnt == SET_W'(SETTLE - 1)) begin
                        state      <= S_IDLE;
                        bus.busy_o <= 1'b0;
                    end else begin
                        set_cnt <= set_cnt + SET_W'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agc_ctrl.sv
// Scoreboarded bench for agc_ctrl: a default instance plus a 12-bit-accumulator
// instance sharing the same stimulus to exercise accumulator saturation.
module tb_agc_ctrl;
    import agc_pkg::*;

    localparam int unsigned NL   = 8;
    localparam int unsigned AB   = 4;
    localparam int unsigned WB   = 24;
    localparam int unsigned AW   = 40;
    localparam int unsigned AW_S = 12;
    localparam int unsigned CW   = WB + 4;

    typedef struct {
        longint sq;
        longint gt;
        longint lt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    agc_ctrl_if #(.NLANE(NL), .ABS_BITS(AB), .WIN_BITS(WB), .ACC_BITS(AW))   bus ();
    agc_ctrl_if #(.NLANE(NL), .ABS_BITS(AB), .WIN_BITS(WB), .ACC_BITS(AW_S)) bus_s ();

    agc_ctrl #(.NLANE(NL), .ABS_BITS(AB), .WIN_BITS(WB), .ACC_BITS(AW), .SETTLE(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    agc_ctrl #(.NLANE(NL), .ABS_BITS(AB), .WIN_BITS(WB), .ACC_BITS(AW_S), .SETTLE(6)) dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_s.slave)
    );

    assign bus_s.scale_dat_i  = bus.scale_dat_i;
    assign bus_s.scale_wr_i   = bus.scale_wr_i;
    assign bus_s.offset_dat_i = bus.offset_dat_i;
    assign bus_s.offset_wr_i  = bus.offset_wr_i;
    assign bus_s.apply_req_i  = bus.apply_req_i;
    assign bus_s.start_i      = bus.start_i;
    assign bus_s.window_len_i = bus.window_len_i;
    assign bus_s.abs_i        = bus.abs_i;
    assign bus_s.gt_i         = bus.gt_i;
    assign bus_s.lt_i         = bus.lt_i;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.scale_dat_i  = '0;
        bus.scale_wr_i   = 1'b0;
        bus.offset_dat_i = '0;
        bus.offset_wr_i  = 1'b0;
        bus.apply_req_i  = 1'b0;
        bus.start_i      = 1'b0;
        bus.window_len_i = '0;
        bus.abs_i        = '0;
        bus.gt_i         = '0;
        bus.lt_i         = '0;
    endtask

    // Drives start at k=0 and lane data every cycle; samples in [offset, offset+len) feed the model.
    task automatic run_window(input int len_in, input int offset, input bit rnd,
                              input logic [3:0] abs_c, input logic [7:0] gt_c, input logic [7:0] lt_c,
                              input int apply_at, input int restart_at,
                              output int n_done, output int n_apply, output int done_k, output int apply_k,
                              output logic [AW-1:0] sq, output logic [AW_S-1:0] sq_s,
                              output logic [CW-1:0] gt, output logic [CW-1:0] lt,
                              output logic [511:0] busy_hist);
        exp_t        e;
        int          eff;
        int          budget;
        logic [31:0] a;
        logic [7:0]  g;
        logic [7:0]  l;
        eff       = (len_in == 0) ? 1 : len_in;
        budget    = offset + eff + 15;
        e         = '{0, 0, 0};
        n_done    = 0;
        n_apply   = 0;
        done_k    = -1;
        apply_k   = -1;
        sq        = '0;
        sq_s      = '0;
        gt        = '0;
        lt        = '0;
        busy_hist = '0;
        bus.window_len_i = WB'(len_in);
        for (int k = 0; k < budget; k++) begin
            for (int n = 0; n < int'(NL); n++) begin
                a[n*4 +: 4] = rnd ? 4'($urandom_range(0, 15)) : abs_c;
            end
            g = rnd ? 8'($urandom) : gt_c;
            l = rnd ? 8'($urandom) : lt_c;
            bus.abs_i       = a;
            bus.gt_i        = g;
            bus.lt_i        = l;
            bus.start_i     = (k == 0) || (k == restart_at);
            bus.apply_req_i = (k == apply_at);
            if (k >= offset && k < offset + eff) begin
                for (int n = 0; n < int'(NL); n++) begin
                    e.sq += longint'(a[n*4 +: 4]) * longint'(a[n*4 +: 4]);
                end
                e.gt += $countones(g);
                e.lt += $countones(l);
            end
            if (k == offset + eff - 1) sb.push_back(e);
            tick();
            busy_hist[k+1] = bus.busy_o;
            if (bus.done_o === 1'b1) begin
                n_done++;
                if (done_k < 0) begin
                    done_k = k + 1;
                    sq     = bus.sq_sum_o;
                    sq_s   = bus_s.sq_sum_o;
                    gt     = bus.gt_cnt_o;
                    lt     = bus.lt_cnt_o;
                end
            end
            if (bus.apply_o === 1'b1) begin
                n_apply++;
                if (apply_k < 0) apply_k = k + 1;
            end
        end
        bus.start_i     = 1'b0;
        bus.apply_req_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.scale_o, bus.offset_o, bus.ce_scale_o, bus.ce_offset_o} !== '0) begin
            errors++;
            $display("FAIL reset_write_outs got %h want 0", {bus.scale_o, bus.offset_o, bus.ce_scale_o, bus.ce_offset_o});
        end
        checks++;
        if ({bus.apply_o, bus.busy_o, bus.done_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl_outs got %b want 000", {bus.apply_o, bus.busy_o, bus.done_o});
        end
        checks++;
        if ({bus.sq_sum_o, bus.gt_cnt_o, bus.lt_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_results got %h want 0", {bus.sq_sum_o, bus.gt_cnt_o, bus.lt_cnt_o});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        bus.scale_dat_i = 17'h01000;
        bus.scale_wr_i  = 1'b1;
        checks++;
        if (bus.ce_scale_o !== 1'b0) begin
            errors++;
            $display("FAIL ce_scale_early got %b want 0", bus.ce_scale_o);
        end
        tick();
        bus.scale_wr_i   = 1'b0;
        bus.scale_dat_i  = 17'h1ABCD;
        bus.offset_dat_i = 12'hF80;
        bus.offset_wr_i  = 1'b1;
        checks++;
        if ({bus.scale_o, bus.ce_scale_o} !== {17'h01000, 1'b1}) begin
            errors++;
            $display("FAIL scale_write got %h/%b want 01000/1", bus.scale_o, bus.ce_scale_o);
        end
        tick();
        bus.offset_wr_i  = 1'b0;
        bus.offset_dat_i = 12'h123;
        checks++;
        if ({bus.scale_o, bus.ce_scale_o} !== {17'h01000, 1'b0}) begin
            errors++;
            $display("FAIL scale_hold got %h/%b want 01000/0", bus.scale_o, bus.ce_scale_o);
        end
        checks++;
        if ({bus.offset_o, bus.ce_offset_o} !== {12'hF80, 1'b1}) begin
            errors++;
            $display("FAIL offset_write got %h/%b want f80/1", bus.offset_o, bus.ce_offset_o);
        end
        tick();
        checks++;
        if ({bus.offset_o, bus.ce_offset_o, bus.apply_o} !== {12'hF80, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL offset_hold_noapply got %h/%b/%b want f80/0/0", bus.offset_o, bus.ce_offset_o, bus.apply_o);
        end
    endtask

    task automatic test_measure();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        run_window(4, 2, 1'b0, 4'd3, 8'h01, 8'h00, -1, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1 || done_k !== 7) begin
            errors++;
            $display("FAIL measure_done got n=%0d at %0d want n=1 at 7", n_done, done_k);
        end
        checks++;
        if (sq !== AW'(e.sq)) begin
            errors++;
            $display("FAIL measure_sq got %0d want %0d", sq, e.sq);
        end
        checks++;
        if (gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL measure_cnt got %0d/%0d want %0d/%0d", gt, lt, e.gt, e.lt);
        end
        checks++;
        if (n_apply !== 0) begin
            errors++;
            $display("FAIL measure_noapply got %0d want 0", n_apply);
        end
    endtask

    task automatic test_deferred_apply();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        run_window(100, 2, 1'b1, 4'd0, 8'h00, 8'h00, 50, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1 || n_apply !== 1 || apply_k !== done_k + 1) begin
            errors++;
            $display("FAIL deferred_order got done=%0d@%0d apply=%0d@%0d want 1 and 1 one cycle later", n_done, done_k, n_apply, apply_k);
        end
        checks++;
        if (sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL deferred_result got %0d/%0d/%0d want %0d/%0d/%0d", sq, gt, lt, e.sq, e.gt, e.lt);
        end
        checks++;
        if (apply_k < 0 || bh[apply_k+6] !== 1'b1 || bh[apply_k+7] !== 1'b0) begin
            errors++;
            $display("FAIL deferred_settle_busy got apply@%0d busy end pattern bad want high 7 cycles", apply_k);
        end
    endtask

    task automatic test_simultaneous();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        run_window(6, 10, 1'b1, 4'd0, 8'h00, 8'h00, 0, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_apply !== 1 || apply_k !== 2 || n_done !== 1 || done_k !== 17) begin
            errors++;
            $display("FAIL simultaneous_seq got apply=%0d@%0d done=%0d@%0d want 1@2 1@17", n_apply, apply_k, n_done, done_k);
        end
        checks++;
        if (sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL simultaneous_result got %0d/%0d/%0d want %0d/%0d/%0d", sq, gt, lt, e.sq, e.gt, e.lt);
        end
    endtask

    task automatic test_len_zero();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        run_window(0, 2, 1'b1, 4'd0, 8'h00, 8'h00, -1, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1 || done_k !== 4) begin
            errors++;
            $display("FAIL len0_done got n=%0d at %0d want n=1 at 4", n_done, done_k);
        end
        checks++;
        if (sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL len0_result got %0d/%0d/%0d want %0d/%0d/%0d", sq, gt, lt, e.sq, e.gt, e.lt);
        end
    endtask

    task automatic test_saturate();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        longint lim;
        run_window(3, 2, 1'b0, 4'hF, 8'hFF, 8'hFF, -1, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e   = sb.pop_front();
        lim = (64'sd1 <<< AW_S) - 1;
        checks++;
        if (sq !== AW'(e.sq)) begin
            errors++;
            $display("FAIL sat_wide_sq got %0d want %0d", sq, e.sq);
        end
        checks++;
        if (sq_s !== AW_S'((e.sq > lim) ? lim : e.sq)) begin
            errors++;
            $display("FAIL sat_narrow_sq got %h want %h", sq_s, AW_S'((e.sq > lim) ? lim : e.sq));
        end
        checks++;
        if (gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL sat_cnt got %0d/%0d want %0d/%0d", gt, lt, e.gt, e.lt);
        end
    endtask

    task automatic test_back_to_back();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        run_window(5, 2, 1'b1, 4'd0, 8'h00, 8'h00, -1, 4, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL b2b_start_in_run got %0d done pulses want 1", n_done);
        end
        checks++;
        if (sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL b2b_first got %0d/%0d/%0d want %0d/%0d/%0d", sq, gt, lt, e.sq, e.gt, e.lt);
        end
        run_window(13, 2, 1'b1, 4'd0, 8'h00, 8'h00, -1, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1 || sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL b2b_second got n=%0d %0d/%0d/%0d want n=1 %0d/%0d/%0d", n_done, sq, gt, lt, e.sq, e.gt, e.lt);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done, n_apply, done_k, apply_k;
        logic [AW-1:0] sq; logic [AW_S-1:0] sq_s; logic [CW-1:0] gt, lt; logic [511:0] bh;
        exp_t e;
        int   late_done;
        late_done = 0;
        bus.window_len_i = WB'(100);
        for (int k = 0; k < 140; k++) begin
            bus.abs_i   = NL*AB'($urandom);
            bus.gt_i    = 8'($urandom);
            bus.lt_i    = 8'($urandom);
            bus.start_i = (k == 0);
            rst         = (k == 52);
            tick();
            if (k == 52) begin
                checks++;
                if ({bus.scale_o, bus.offset_o, bus.ce_scale_o, bus.ce_offset_o, bus.apply_o,
                     bus.busy_o, bus.done_o, bus.sq_sum_o, bus.gt_cnt_o, bus.lt_cnt_o} !== '0) begin
                    errors++;
                    $display("FAIL midrun_reset_outs got busy=%b sq=%0d scale=%h want all 0", bus.busy_o, bus.sq_sum_o, bus.scale_o);
                end
            end
            if (bus.done_o === 1'b1) late_done++;
        end
        rst         = 1'b0;
        bus.start_i = 1'b0;
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done got %0d done pulses want 0", late_done);
        end
        run_window(10, 2, 1'b1, 4'd0, 8'h00, 8'h00, -1, -1, n_done, n_apply, done_k, apply_k, sq, sq_s, gt, lt, bh);
        e = sb.pop_front();
        checks++;
        if (n_done !== 1 || sq !== AW'(e.sq) || gt !== CW'(e.gt) || lt !== CW'(e.lt)) begin
            errors++;
            $display("FAIL midrun_recover got n=%0d %0d/%0d/%0d want n=1 %0d/%0d/%0d", n_done, sq, gt, lt, e.sq, e.gt, e.lt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired want run to finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_measure();
        test_deferred_apply();
        test_simultaneous();
        test_len_zero();
        test_saturate();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
